// File: rtl/usb_speed_signaller.sv
// Device-side USB attach-sequence generator: drives SE0/J/SE0/J linestate patterns for LS, FS or HS.
// Optional abort input is enabled with the USB_SIGGEN_ABORT_EN macro.

`ifndef USB_SPEED_AUTO
`define USB_SPEED_AUTO 2'd0
`endif
`ifndef USB_SPEED_LS
`define USB_SPEED_LS 2'd1
`endif
`ifndef USB_SPEED_FS
`define USB_SPEED_FS 2'd2
`endif
`ifndef USB_SPEED_HS
`define USB_SPEED_HS 2'd3
`endif

module usb_speed_signaller #(
   parameter int pCOUNTER_WIDTH = 24,
   parameter int pWAIT_0_START  = 8,
   parameter int pMARGIN        = 2,
   parameter int pREHIGH        = 4
) (
   input  logic                      fe_clk,
   input  logic                      reset_i,
   input  logic                      I_start,
   input  logic [1:0]                I_speed,
   input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
   input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
`ifdef USB_SIGGEN_ABORT_EN
   input  logic                      I_abort,
`endif
   output logic [1:0]                O_linestate,
   output logic                      O_busy,
   output logic                      O_done,
   output logic                      O_error
);

   typedef logic [pCOUNTER_WIDTH:0] cnt_t;
   typedef enum logic [2:0] {IDLE, START, HIGH, LOW, REHIGH} state_t;

   localparam cnt_t ONE       = {{pCOUNTER_WIDTH{1'b0}}, 1'b1};
   localparam cnt_t TWO       = {{(pCOUNTER_WIDTH-1){1'b0}}, 2'b10};
   localparam cnt_t MARGIN_X  = cnt_t'(pMARGIN);
   localparam cnt_t START_M1  = cnt_t'((pWAIT_0_START > 0) ? pWAIT_0_START - 1 : 0);
   localparam cnt_t REHIGH_M1 = cnt_t'((pREHIGH > 0) ? pREHIGH - 1 : 0);

   state_t                    state_r;
   cnt_t                      cnt_r;
   logic [1:0]                speed_r;
   logic [pCOUNTER_WIDTH-1:0] wait1_r;
   logic [pCOUNTER_WIDTH-1:0] wait2_r;
   logic [1:0]                ls_r;
   logic                      busy_r;
   logic                      done_r;
   logic                      error_r;

   logic                      abort_s;
   logic                      speed_ok_s;
   logic [1:0]                j_s;
   cnt_t                      w1x_s;
   cnt_t                      n1_m1_s;
   cnt_t                      hs_sum_s;
   cnt_t                      n2_fs_m1_s;
   cnt_t                      n2_hs_m1_s;
   cnt_t                      n2_m1_s;

   // Phase lengths (minus one, counters run down to zero) and J encoding from the latched request
   always_comb begin
      w1x_s      = {1'b0, wait1_r};
      n1_m1_s    = '0;
      hs_sum_s   = '0;
      n2_fs_m1_s = '0;
      n2_hs_m1_s = '0;
      n2_m1_s    = '0;
      speed_ok_s = 1'b0;
      j_s        = 2'b01;
      abort_s    = 1'b0;
`ifdef USB_SIGGEN_ABORT_EN
      abort_s = I_abort;
`else
      abort_s = 1'b0;
`endif
      if (wait1_r == '0) begin
         w1x_s = ONE;
      end else begin
         w1x_s = {1'b0, wait1_r};
      end
      n1_m1_s = w1x_s + MARGIN_X - ONE;
      // FS low phase sits one cycle under the threshold, never shorter than a single cycle
      if ({1'b0, wait2_r} <= TWO) begin
         n2_fs_m1_s = '0;
      end else begin
         n2_fs_m1_s = {1'b0, wait2_r} - TWO;
      end
      hs_sum_s = {1'b0, wait2_r} + MARGIN_X;
      if (hs_sum_s == '0) begin
         n2_hs_m1_s = '0;
      end else begin
         n2_hs_m1_s = hs_sum_s - ONE;
      end
      if (speed_r == `USB_SPEED_HS) begin
         n2_m1_s = n2_hs_m1_s;
      end else begin
         n2_m1_s = n2_fs_m1_s;
      end
      if (speed_r == `USB_SPEED_LS) begin
         j_s = 2'b10;
      end else begin
         j_s = 2'b01;
      end
      case (I_speed)
         `USB_SPEED_LS, `USB_SPEED_FS, `USB_SPEED_HS: speed_ok_s = 1'b1;
         default:                                     speed_ok_s = 1'b0;
      endcase
   end

   // Sequencer FSM with registered linestate, busy and status pulses
   always_ff @(posedge fe_clk) begin
      if (reset_i) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         speed_r <= 2'b00;
         wait1_r <= '0;
         wait2_r <= '0;
         ls_r    <= 2'b00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         done_r  <= 1'b0;
         error_r <= 1'b0;
         if (abort_s && (state_r != IDLE)) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            ls_r    <= 2'b00;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  ls_r   <= 2'b00;
                  busy_r <= 1'b0;
                  if (I_start) begin
                     if (speed_ok_s) begin
                        speed_r <= I_speed;
                        wait1_r <= I_wait1;
                        wait2_r <= I_wait2;
                        cnt_r   <= START_M1;
                        busy_r  <= 1'b1;
                        state_r <= START;
                     end else begin
                        error_r <= 1'b1;
                     end
                  end
               end
               START: begin
                  if (cnt_r == '0) begin
                     state_r <= HIGH;
                     ls_r    <= j_s;
                     cnt_r   <= n1_m1_s;
                  end else begin
                     cnt_r <= cnt_r - ONE;
                  end
               end
               HIGH: begin
                  if (cnt_r == '0) begin
                     ls_r <= 2'b00;
                     if (speed_r == `USB_SPEED_LS) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                     end else begin
                        state_r <= LOW;
                        cnt_r   <= n2_m1_s;
                     end
                  end else begin
                     cnt_r <= cnt_r - ONE;
                  end
               end
               LOW: begin
                  if (cnt_r == '0) begin
                     state_r <= REHIGH;
                     ls_r    <= j_s;
                     cnt_r   <= REHIGH_M1;
                  end else begin
                     cnt_r <= cnt_r - ONE;
                  end
               end
               REHIGH: begin
                  if (cnt_r == '0) begin
                     state_r <= IDLE;
                     ls_r    <= 2'b00;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r - ONE;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
                  ls_r    <= 2'b00;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign O_linestate = ls_r;
   assign O_busy      = busy_r;
   assign O_done      = done_r;
   assign O_error     = error_r;

endmodule

// File: tb/tb_usb_speed_signaller.sv
// Self-checking bench for usb_speed_signaller: table of start requests plus hand-built corner sequences,
// checked cycle by cycle against a queue of expected outputs.

module tb_usb_speed_signaller;

   localparam logic [1:0] SP_AUTO = 2'd0;
   localparam logic [1:0] SP_LS   = 2'd1;
   localparam logic [1:0] SP_FS   = 2'd2;
   localparam logic [1:0] SP_HS   = 2'd3;
   localparam int S = 8;
   localparam int M = 2;
   localparam int R = 4;

   logic        fe_clk;
   logic        reset_i;
   logic        I_start;
   logic [1:0]  I_speed;
   logic [23:0] I_wait1;
   logic [23:0] I_wait2;
   logic        I_abort;
   logic [1:0]  O_linestate;
   logic        O_busy;
   logic        O_done;
   logic        O_error;

   typedef struct packed {
      logic [1:0] ls;
      logic       busy;
      logic       done;
      logic       err;
   } obs_t;

   typedef struct {
      logic [1:0] speed;
      int         w1;
      int         w2;
      int         exp_done;
   } vec_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   usb_speed_signaller #(
      .pCOUNTER_WIDTH(24),
      .pWAIT_0_START(S),
      .pMARGIN(M),
      .pREHIGH(R)
   ) dut (
      .fe_clk(fe_clk),
      .reset_i(reset_i),
      .I_start(I_start),
      .I_speed(I_speed),
      .I_wait1(I_wait1),
      .I_wait2(I_wait2),
`ifdef USB_SIGGEN_ABORT_EN
      .I_abort(I_abort),
`endif
      .O_linestate(O_linestate),
      .O_busy(O_busy),
      .O_done(O_done),
      .O_error(O_error)
   );

   initial fe_clk = 1'b0;
   always #5 fe_clk = ~fe_clk;

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got == want) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, want);
   endtask

   task automatic push_n(input int n, input logic [1:0] ls, input logic busy, input logic done, input logic err);
      obs_t e;
      e = '{ls: ls, busy: busy, done: done, err: err};
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   // Reference model: expected per-cycle outputs for one start request, from cycle 1 on
   task automatic build(input logic [1:0] speed, input int w1, input int w2);
      logic [1:0] j;
      int n1;
      int n2;
      if (speed != SP_LS && speed != SP_FS && speed != SP_HS) begin
         push_n(1, 2'b00, 1'b0, 1'b0, 1'b1);
         push_n(1, 2'b00, 1'b0, 1'b0, 1'b0);
      end else begin
         j  = (speed == SP_LS) ? 2'b10 : 2'b01;
         n1 = ((w1 == 0) ? 1 : w1) + M;
         push_n(S, 2'b00, 1'b1, 1'b0, 1'b0);
         push_n(n1, j, 1'b1, 1'b0, 1'b0);
         if (speed != SP_LS) begin
            if (speed == SP_FS) n2 = (w2 - 1 < 1) ? 1 : w2 - 1;
            else                n2 = w2 + M;
            push_n(n2, 2'b00, 1'b1, 1'b0, 1'b0);
            push_n(R, j, 1'b1, 1'b0, 1'b0);
         end
         push_n(1, 2'b00, 1'b0, 1'b1, 1'b0);
         push_n(1, 2'b00, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic drain(input string name, input int extra_at, input int rst_at, input int abort_at,
                        output int done_cyc);
      int   cyc;
      obs_t got;
      obs_t e;
      cyc      = 0;
      done_cyc = 0;
      while (exp_q.size() > 0) begin
         @(posedge fe_clk);
         #1;
         cyc++;
         I_start = 1'b0;
         reset_i = 1'b0;
         I_abort = 1'b0;
         got = '{ls: O_linestate, busy: O_busy, done: O_done, err: O_error};
         e   = exp_q.pop_front();
         checks++;
         if (got == e) passed++;
         else $display("FAIL %s cycle %0d: got ls=%b busy=%b done=%b err=%b, expected ls=%b busy=%b done=%b err=%b (abort=%b)",
                       name, cyc, got.ls, got.busy, got.done, got.err, e.ls, e.busy, e.done, e.err, I_abort);
         if (O_done && done_cyc == 0) done_cyc = cyc;
         if (cyc == extra_at) begin
            I_start = 1'b1;
            I_speed = SP_LS;
         end
         if (cyc == rst_at) reset_i = 1'b1;
         if (cyc == abort_at) I_abort = 1'b1;
      end
   endtask

   task automatic kick(input logic [1:0] speed, input int w1, input int w2);
      @(negedge fe_clk);
      I_start = 1'b1;
      I_speed = speed;
      I_wait1 = 24'(w1);
      I_wait2 = 24'(w2);
   endtask

   initial begin
      vec_t vecs[8];
      int   dc;
      vecs[0] = '{speed: SP_LS,   w1: 32, w2: 32, exp_done: 43};
      vecs[1] = '{speed: SP_FS,   w1: 32, w2: 32, exp_done: 78};
      vecs[2] = '{speed: SP_HS,   w1: 32, w2: 32, exp_done: 81};
      vecs[3] = '{speed: SP_AUTO, w1: 32, w2: 32, exp_done: 0};
      vecs[4] = '{speed: SP_LS,   w1: 0,  w2: 5,  exp_done: 12};
      vecs[5] = '{speed: SP_FS,   w1: 1,  w2: 1,  exp_done: 17};
      vecs[6] = '{speed: SP_FS,   w1: 1,  w2: 2,  exp_done: 17};
      vecs[7] = '{speed: SP_HS,   w1: 5,  w2: 0,  exp_done: 22};

      reset_i = 1'b1;
      I_start = 1'b0;
      I_speed = SP_AUTO;
      I_wait1 = 24'd0;
      I_wait2 = 24'd0;
      I_abort = 1'b0;
      repeat (2) @(posedge fe_clk);
      #1;
      check_int("reset_outputs", int'({O_linestate, O_busy, O_done, O_error}), 0);
      reset_i = 1'b0;

      for (int i = 0; i < 8; i++) begin
         kick(vecs[i].speed, vecs[i].w1, vecs[i].w2);
         build(vecs[i].speed, vecs[i].w1, vecs[i].w2);
         drain($sformatf("vec%0d", i), 0, 0, 0, dc);
         check_int($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
      end

      // Second start mid-run must not disturb an FS sequence
      kick(SP_FS, 32, 32);
      build(SP_FS, 32, 32);
      drain("fs_extra_start", 20, 0, 0, dc);
      check_int("fs_extra_start_done_cycle", dc, 78);

      // Reset during the LS high phase: idle next cycle, no done afterwards
      kick(SP_LS, 32, 32);
      push_n(S, 2'b00, 1'b1, 1'b0, 1'b0);
      push_n(20 - S, 2'b10, 1'b1, 1'b0, 1'b0);
      push_n(30, 2'b00, 1'b0, 1'b0, 1'b0);
      drain("ls_reset", 0, 20, 0, dc);
      check_int("ls_reset_no_done", dc, 0);

`ifdef USB_SIGGEN_ABORT_EN
      kick(SP_LS, 32, 32);
      push_n(S, 2'b00, 1'b1, 1'b0, 1'b0);
      push_n(20 - S, 2'b10, 1'b1, 1'b0, 1'b0);
      push_n(30, 2'b00, 1'b0, 1'b0, 1'b0);
      drain("ls_abort", 0, 0, 20, dc);
      check_int("ls_abort_no_done", dc, 0);

      kick(SP_LS, 32, 32);
      push_n(S, 2'b00, 1'b1, 1'b0, 1'b0);
      push_n(34, 2'b10, 1'b1, 1'b0, 1'b0);
      push_n(10, 2'b00, 1'b0, 1'b0, 1'b0);
      drain("ls_abort_last_high", 0, 0, 42, dc);
      check_int("ls_abort_last_high_no_done", dc, 0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
